// File: rtl/uart_bus_bridge.sv
// Host command bridge: UART RX bytes -> framed 32-bit bus read/write -> UART TX reply.
// Latency: one RX byte consumed every two cycles; bus phase waits for busAck; reply one byte per two cycles.
// Backpressure: rxPop only while rxValid, txPush only after txReady; a stalled bus holds until reset.
module uart_bus_bridge #(
    parameter int TIMEOUT = 100_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rxByte,
    input  logic        rxValid,
    output logic        rxPop,
    output logic [7:0]  txByte,
    output logic        txPush,
    input  logic        txReady,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    output logic        busWrite,
    output logic        busRead,
    input  logic [31:0] busRData,
    input  logic        busAck,
    output logic        idle
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TIMER_RELOAD = CW'(TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] REPLY_ACK = 8'h06;
    localparam logic [7:0] REPLY_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS,
        RESP,
        NAK
    } state_t;

    state_t         state;
    logic           cmdWrite;   // held opcode of the current frame: 1 = write, 0 = read
    logic [1:0]     idx;        // byte index within ADDR/DATA/RESP
    logic [31:0]    rdData;     // read data captured on busAck
    logic [CW-1:0]  timer;      // inter-byte timeout inside a frame
    logic [7:0]     respByte;

    assign idle = (state == IDLE);

    // Select the reply byte for the current RESP index (write: single ack, read: data MSB first).
    always_comb begin
        respByte = REPLY_ACK;
        if (!cmdWrite) begin
            case (idx)
                2'd0:    respByte = rdData[31:24];
                2'd1:    respByte = rdData[23:16];
                2'd2:    respByte = rdData[15:8];
                default: respByte = rdData[7:0];
            endcase
        end
    end

    // Frame FSM; rxPop/txPush are registered strobes, the byte is consumed/pushed while the strobe is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cmdWrite <= 1'b0;
            idx      <= 2'd0;
            rdData   <= 32'd0;
            timer    <= '0;
            rxPop    <= 1'b0;
            txPush   <= 1'b0;
            txByte   <= 8'd0;
            busAddr  <= 32'd0;
            busWData <= 32'd0;
            busWrite <= 1'b0;
            busRead  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rxPop) begin
                        rxPop <= 1'b0;
                        idx   <= 2'd0;
                        timer <= TIMER_RELOAD;
                        if (rxByte == CMD_WRITE) begin
                            cmdWrite <= 1'b1;
                            state    <= ADDR;
                        end else if (rxByte == CMD_READ) begin
                            cmdWrite <= 1'b0;
                            state    <= ADDR;
                        end else begin
                            state <= NAK;
                        end
                    end else begin
                        rxPop <= rxValid;
                    end
                end

                ADDR: begin
                    if (rxPop) begin
                        rxPop   <= 1'b0;
                        busAddr <= {busAddr[23:0], rxByte};
                        timer   <= TIMER_RELOAD;
                        idx     <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= cmdWrite ? DATA : BUS;
                        end
                    end else if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                        rxPop <= rxValid;
                    end
                end

                DATA: begin
                    if (rxPop) begin
                        rxPop    <= 1'b0;
                        busWData <= {busWData[23:0], rxByte};
                        timer    <= TIMER_RELOAD;
                        idx      <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            state <= BUS;
                        end
                    end else if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                        rxPop <= rxValid;
                    end
                end

                BUS: begin
                    if (busRead || busWrite) begin
                        if (busAck) begin
                            busRead  <= 1'b0;
                            busWrite <= 1'b0;
                            rdData   <= busRData;
                            idx      <= 2'd0;
                            state    <= RESP;
                        end
                    end else begin
                        busWrite <= cmdWrite;
                        busRead  <= !cmdWrite;
                    end
                end

                RESP: begin
                    if (txPush) begin
                        txPush <= 1'b0;
                        if (cmdWrite || idx == 2'd3) begin
                            state <= IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else if (txReady) begin
                        txPush <= 1'b1;
                        txByte <= respByte;
                    end
                end

                NAK: begin
                    if (txPush) begin
                        txPush <= 1'b0;
                        state  <= IDLE;
                    end else if (txReady) begin
                        txPush <= 1'b1;
                        txByte <= REPLY_NAK;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
